// File: rtl/riscv_mem_unit.sv
// Unified instruction/data memory with programmable wait states and a req/ready handshake.
// Handles sb/sh/sw lane merging and lb/lh/lbu/lhu/lw extension; misaligned accesses return err.
module riscv_mem_unit #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  func3,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            we_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      f_q;
    logic [31:0]     mem [DEPTH];

    logic            misaligned;
    logic            do_access;
    logic [AW-1:0]   idx;
    logic [31:0]     word;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     load_v;
    logic [3:0]      be;
    logic [31:0]     wmerge;

    // Bits above the word index wrap the address space and are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    // func3[1] set means word size, which also covers the undefined encodings.
    assign misaligned = (func3[1:0] == 2'b01 && addr[0]) ||
                        (func3[1] && addr[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = misaligned ? DONE : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign do_access = (state == WAIT) && (cnt == 4'd0);
    assign ready     = (state == DONE);
    assign idx       = addr_q[AW+1:2];
    assign word      = mem[idx];

    always_comb begin
        byte_v = 8'(word >> {addr_q[1:0], 3'b000});
        half_v = addr_q[1] ? word[31:16] : word[15:0];
        case (f_q[1:0])
            2'b00:   load_v = f_q[2] ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_v = f_q[2] ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_v = word;
        endcase
    end

    always_comb begin
        case (f_q[1:0])
            2'b00: begin
                be     = 4'b0001 << addr_q[1:0];
                wmerge = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wmerge = {2{wdata_q[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wmerge = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f_q     <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req) begin
                    we_q    <= we;
                    addr_q  <= addr[AW+1:0];
                    wdata_q <= wdata;
                    f_q     <= func3;
                    cnt     <= 4'(LATENCY);
                    if (misaligned) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata <= we_q ? 32'd0 : load_v;
                        err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is intentionally left uninitialised across reset.
    always_ff @(posedge clk) begin
        if (do_access && we_q) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wmerge[8*i +: 8];
        end
    end
endmodule
